// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: I2C target exposing NUM_REGS x 8-bit registers with
// pointer addressing, auto-increment on write and read, and read-back.
// Optional build macro I2C_GLITCH_FILTER_EN adds a 3-tap majority filter
// behind the scl/sda synchronisers (edge-to-action latency 5 clk instead of 3).
module i2c_slave_regbank #(
   parameter logic [6:0] SLV_ADDR = 7'h50,
   parameter int         NUM_REGS = 4,
   parameter int         PTR_W    = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   inout  wire                   sda,
   input  logic                  scl,
   output logic [NUM_REGS*8-1:0] regs,
   output logic                  wr_stb,
   output logic [PTR_W-1:0]      wr_idx,
   output logic                  busy,
   output logic                  ready
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
   } state_t;

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REGS - 1);

   state_t                    state, state_nxt;
   logic [1:0]                sync0, sync1;   // {scl, sda}
   logic [1:0]                filt;           // cleaned line values
   logic [1:0]                line_q;         // previous cleaned values
   logic [3:0]                bit_cnt;
   logic [7:0]                sr;
   logic [PTR_W-1:0]          ptr;
   logic [NUM_REGS-1:0][7:0]  regs_q;
   logic                      sda_oe;

   // Two-flop synchroniser for both bus lines; idle bus is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync0 <= 2'b11;
         sync1 <= 2'b11;
      end else begin
         sync0 <= {scl, sda};
         sync1 <= sync0;
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] tap1, tap2;

   // Majority of three consecutive samples: a single-clk pulse never wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tap1 <= 2'b11;
         tap2 <= 2'b11;
         filt <= 2'b11;
      end else begin
         tap1 <= sync1;
         tap2 <= tap1;
         filt <= (sync1 & tap1) | (sync1 & tap2) | (tap1 & tap2);
      end
   end
`else
   assign filt = sync1;
`endif

   // Delayed copy of the cleaned lines for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) line_q <= 2'b11;
      else        line_q <= filt;
   end

   wire scl_f    = filt[1];
   wire sda_f    = filt[0];
   wire scl_q    = line_q[1];
   wire sda_q    = line_q[0];
   wire scl_rise = scl_f & ~scl_q;
   wire scl_fall = ~scl_f & scl_q;
   wire start_c  = scl_f & scl_q & sda_q & ~sda_f;
   wire stop_c   = scl_f & scl_q & ~sda_q & sda_f;
   wire byte_end = scl_fall && (bit_cnt == 4'd8);
   wire ptr_ok   = ({1'b0, sr} < 9'(NUM_REGS));
   wire [PTR_W-1:0] ptr_inc = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: bus conditions override any bit-level progress.
   always_comb begin
      state_nxt = state;
      if (start_c) begin
         state_nxt = ADDR;
      end else if (stop_c) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            ADDR:      if (byte_end) state_nxt = (sr[7:1] == SLV_ADDR) ? ADDR_ACK : IGNORE;
            ADDR_ACK:  if (scl_fall) state_nxt = sr[0] ? RDATA : PTR;
            PTR:       if (byte_end) state_nxt = ptr_ok ? PTR_ACK : IGNORE;
            PTR_ACK:   if (scl_fall) state_nxt = WDATA;
            WDATA:     if (byte_end) state_nxt = WDATA_ACK;
            WDATA_ACK: if (scl_fall) state_nxt = WDATA;
            RDATA:     if (byte_end) state_nxt = RACK;
            RACK: begin
               if (scl_rise && sda_f) state_nxt = IGNORE;
               else if (scl_fall)     state_nxt = RDATA;
            end
            default:   state_nxt = state;
         endcase
      end
   end

   // Outputs decoded from state: open-drain drive and transaction flag.
   always_comb begin
      sda_oe = 1'b0;
      busy   = 1'b0;
      case (state)
         ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            sda_oe = 1'b1;
            busy   = 1'b1;
         end
         PTR, WDATA, RACK: busy = 1'b1;
         RDATA: begin
            sda_oe = ~sr[7];
            busy   = 1'b1;
         end
         default: ;
      endcase
   end

   assign ready = ~busy;
   assign sda   = sda_oe ? 1'b0 : 1'bz;
   assign regs  = regs_q;

   // Shift register, bit counter, pointer and register bank.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt <= '0;
         sr      <= '0;
         ptr     <= '0;
         regs_q  <= '0;
         wr_stb  <= 1'b0;
         wr_idx  <= '0;
      end else begin
         wr_stb <= 1'b0;
         if (start_c || stop_c) begin
            // A partial byte is simply dropped; nothing was committed yet.
            bit_cnt <= '0;
         end else begin
            case (state)
               ADDR, PTR, WDATA: begin
                  if (scl_rise && bit_cnt != 4'd8) begin
                     sr      <= {sr[6:0], sda_f};
                     bit_cnt <= bit_cnt + 4'd1;
                  end
                  if (state == PTR && byte_end && ptr_ok)
                     ptr <= sr[PTR_W-1:0];
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     bit_cnt <= '0;
                     if (sr[0]) sr <= regs_q[ptr];
                  end
               end
               PTR_ACK: begin
                  if (scl_fall) bit_cnt <= '0;
               end
               WDATA_ACK: begin
                  // Commit on the ninth rising edge, while the ACK is on the bus.
                  if (scl_rise) begin
                     regs_q[ptr] <= sr;
                     wr_stb      <= 1'b1;
                     wr_idx      <= ptr;
                     ptr         <= ptr_inc;
                  end
                  if (scl_fall) bit_cnt <= '0;
               end
               RDATA: begin
                  if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                  if (scl_fall && bit_cnt != 4'd8) sr <= {sr[6:0], 1'b0};
               end
               RACK: begin
                  // Pointer advances on both ACK and NACK.
                  if (scl_rise) ptr <= ptr_inc;
                  if (scl_fall) begin
                     sr      <= regs_q[ptr];
                     bit_cnt <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bench for i2c_slave_regbank: bit-banged I2C master, transaction-level
// register model, directed cases followed by randomized transactions.
module tb_i2c_slave_regbank;
   localparam int         NUM_REGS = 4;
   localparam int         PTR_W    = 2;
   localparam logic [6:0] SLV      = 7'h50;
   localparam int         Q        = 6;   // quarter scl period in clk

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic scl   = 1'b1;
   logic m_oe  = 1'b0;
   wire  sda;
   logic [NUM_REGS*8-1:0] regs;
   logic                  wr_stb;
   logic [PTR_W-1:0]      wr_idx;
   logic                  busy, ready;

   assign sda = m_oe ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_slave_regbank #(.SLV_ADDR(SLV), .NUM_REGS(NUM_REGS)) dut (
      .clk(clk), .reset(reset), .sda(sda), .scl(scl),
      .regs(regs), .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy), .ready(ready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: register contents, pointer, expected strobe indices.
   logic [7:0] mem [NUM_REGS];
   int         mptr;
   int         exp_stb[$];
   int         got_stb[$];
   logic [7:0] wq[$];

   always @(negedge clk) if (wr_stb) got_stb.push_back(int'(wr_idx));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic ncyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      foreach (mem[i]) mem[i] = 8'h00;
      mptr = 0;
      exp_stb.delete();
      got_stb.delete();
   endtask

   task automatic put_bit(input bit b, input bit glitch);
      m_oe = ~b;
      if (glitch) begin
         ncyc(3); scl = 1'b1; ncyc(1); scl = 1'b0; ncyc(Q - 4);
      end else begin
         ncyc(Q);
      end
      scl = 1'b1; ncyc(2 * Q);
      scl = 1'b0; ncyc(Q);
   endtask

   task automatic get_bit(output bit b);
      m_oe = 1'b0; ncyc(Q);
      scl = 1'b1;  ncyc(Q);
      b = sda;     ncyc(Q);
      scl = 1'b0;  ncyc(Q);
   endtask

   task automatic i2c_start();
      m_oe = 1'b0; ncyc(Q);
      scl = 1'b1;  ncyc(Q);
      m_oe = 1'b1; ncyc(Q);
      scl = 1'b0;  ncyc(Q);
   endtask

   task automatic i2c_stop();
      m_oe = 1'b1; ncyc(Q);
      scl = 1'b1;  ncyc(Q);
      m_oe = 1'b0; ncyc(Q);
   endtask

   task automatic send_byte(input logic [7:0] v, input int gbit, output bit ack);
      bit nb;
      for (int i = 7; i >= 0; i--) put_bit(v[i], i == gbit);
      get_bit(nb);
      ack = ~nb;
   endtask

   task automatic recv_byte(input bit ack, output logic [7:0] v);
      bit b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         v[i] = b;
      end
      put_bit(~ack, 1'b0);
   endtask

   task automatic settle_check();
      ncyc(4);
      chk("busy_idle", busy, 0);
      chk("ready_idle", ready, 1);
      for (int r = 0; r < NUM_REGS; r++) chk("regs", regs[8*r +: 8], mem[r]);
      chk("stb_count", got_stb.size(), exp_stb.size());
      if (got_stb.size() == exp_stb.size())
         foreach (exp_stb[i]) chk("stb_idx", got_stb[i], exp_stb[i]);
      exp_stb.delete();
      got_stb.delete();
   endtask

   task automatic check_reset_state();
      chk("rst_sda", sda, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready, 1);
      chk("rst_wr_stb", wr_stb, 0);
      chk("rst_wr_idx", wr_idx, 0);
      chk("rst_regs", regs, 0);
   endtask

   // Write transaction: address a, then bytes in wq (first is the pointer).
   task automatic xfer_write(input logic [6:0] a, input int gbit);
      bit ack, ok;
      i2c_start();
      send_byte({a, 1'b0}, -1, ack);
      ok = (a == SLV);
      chk("addr_ack", ack, ok);
      chk("busy_after_addr", busy, ok);
      foreach (wq[i]) begin
         send_byte(wq[i], (i == 1) ? gbit : -1, ack);
         if (i == 0) begin
            if (ok) begin
               ok = (wq[0] < NUM_REGS);
               if (ok) mptr = int'(wq[0]);
            end
            chk("ptr_ack", ack, ok);
            chk("busy_after_ptr", busy, ok);
         end else begin
            if (ok) begin
               mem[mptr] = wq[i];
               exp_stb.push_back(mptr);
               mptr = (mptr + 1) % NUM_REGS;
            end
            chk("data_ack", ack, ok);
         end
      end
      i2c_stop();
      settle_check();
   endtask

   // Read transaction: optional pointer set + repeated START, then n bytes.
   task automatic xfer_read(input int p, input int n);
      bit         ack;
      logic [7:0] v;
      i2c_start();
      if (p >= 0) begin
         send_byte({SLV, 1'b0}, -1, ack); chk("rd_waddr_ack", ack, 1);
         send_byte(8'(p), -1, ack);       chk("rd_ptr_ack", ack, 1);
         mptr = p;
         i2c_start();
      end
      send_byte({SLV, 1'b1}, -1, ack);
      chk("rd_addr_ack", ack, 1);
      chk("busy_rd", busy, 1);
      for (int k = 0; k < n; k++) begin
         recv_byte(k != n - 1, v);
         chk("rd_data", v, mem[mptr]);
         mptr = (mptr + 1) % NUM_REGS;
      end
      chk("rd_release", sda, 1);
      chk("busy_after_nack", busy, 0);
      i2c_stop();
      settle_check();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ack;
      int         kind, n;
      logic [6:0] a;

      #1 reset = 1'b0;
      ncyc(3);
      check_reset_state();
      reset = 1'b1;
      ncyc(5);
      model_reset();

      // Reset asserted while the slave is driving a 0 data bit.
      wq = '{8'h01, 8'h11};
      xfer_write(SLV, -1);
      i2c_start();
      send_byte({SLV, 1'b0}, -1, ack);
      send_byte(8'h01, -1, ack);
      i2c_start();
      send_byte({SLV, 1'b1}, -1, ack);
      chk("mid_rd_ack", ack, 1);
      chk("mid_rd_drive", sda, 0);
      reset = 1'b0;
      ncyc(1);
      check_reset_state();
      scl  = 1'b1;
      m_oe = 1'b0;
      ncyc(3);
      reset = 1'b1;
      ncyc(5);
      model_reset();

      // Burst write with auto-increment.
      wq = '{8'h01, 8'h11, 8'h22, 8'h33};
      xfer_write(SLV, -1);
      // Pointer wrap on write.
      wq = '{8'h03, 8'hAA, 8'hBB};
      xfer_write(SLV, -1);
      // Pointer set, repeated START, read with wrap.
      xfer_read(2, 3);
      // Wrong device address.
      wq = '{8'h00, 8'h55};
      xfer_write(7'h51, -1);
      // Out-of-range pointer.
      wq = '{8'h07, 8'h99};
      xfer_write(SLV, -1);

`ifdef I2C_GLITCH_FILTER_EN
      // One-clk scl glitch in the low phase of a data bit.
      wq = '{8'h00, 8'h5A};
      xfer_write(SLV, 3);
`endif

      for (int it = 0; it < 20; it++) begin
         kind = int'($urandom_range(0, 3));
         if (kind <= 1) begin
            wq.delete();
            wq.push_back(8'($urandom_range(0, NUM_REGS + 3)));
            n = int'($urandom_range(0, 4));
            for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
            xfer_write(SLV, -1);
         end else if (kind == 2) begin
            xfer_read(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NUM_REGS - 1)) : -1,
                      int'($urandom_range(1, 5)));
         end else begin
            a = 7'($urandom);
            if (a == SLV) a = a ^ 7'h01;
            wq = '{8'($urandom_range(0, NUM_REGS - 1)), 8'($urandom)};
            xfer_write(a, -1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regbank.md
Name: i2c_slave_regbank

Overview:
- Parametrised successor to the fixed 4-register I2C slave: addressable I2C target exposing NUM_REGS × 8-bit registers with pointer addressing, auto-increment and read-back.
- Sits between the board SDA/SCL pins and user logic (FND/GPIO selection), which consumes the flat register bus and write strobes.
- Master is the in-house I2C master.
- SCL is assumed to be ≤ clk/16.

Parameters:
- SLV_ADDR, 7'h50: 7-bit device address matched after START.
- NUM_REGS, 4: register count, 2..256.
- PTR_W, $clog2(NUM_REGS): pointer width (derived, do not override).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- sda  inout  1  I2C data, open-drain: driven 0 or released to 'z only
- scl  input  1  I2C clock (slave never stretches)
- regs  output  NUM_REGS*8  flat register bus; reg i at bits [8i+7:8i]
- wr_stb  output  1  one-clk pulse when a register is written
- wr_idx  output  PTR_W  index of the register written (valid with wr_stb)
- busy  output  1  high from matched-address ACK until STOP/START/abort
- ready  output  1  inverse of busy

Behaviour:
- Reset: asynchronous assertion when reset=0. On reset:
  - all regs = 0, pointer = 0;
  - wr_stb = 0, wr_idx = 0, busy = 0, ready = 1;
  - sda released;
  - FSM in IDLE.
  - Reset mid-transfer releases sda immediately.
- Input sampling:
  - scl/sda pass through 2-FF synchronisers.
  - Edges are detected on the synchronised values.
  - Edge-to-action latency is 3 clk.
- Bus conditions:
  - START = sda fall while scl high; from any state → ADDR, bit count cleared. This also covers repeated START.
  - STOP = sda rise while scl high; from any state → IDLE, sda released.
- Bit timing:
  - Data bits are sampled on scl rising edges, MSB first.
  - The slave changes sda only on scl falling edges.
  - The ACK slot drives sda=0 from the falling edge after bit 8 to the falling edge after bit 9.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
  - ADDR: shift 8 bits.
    - addr[7:1]==SLV_ADDR → ADDR_ACK (ACK).
    - Otherwise → IGNORE (no drive until START/STOP).
  - ADDR_ACK:
    - R/W=0 → PTR.
    - R/W=1 → RDATA, loading the shift register with reg[pointer].
    - busy=1 from the ACK falling edge.
  - PTR: receive byte b.
    - b < NUM_REGS: pointer=b[PTR_W-1:0], ACK, → PTR_ACK → WDATA.
    - b ≥ NUM_REGS: NACK (sda released), pointer unchanged, → IGNORE.
  - WDATA: receive byte.
    - Ninth-bit rising edge writes reg[pointer] and pulses wr_stb for exactly 1 clk, with wr_idx=pointer.
    - Pointer += 1, wrapping from NUM_REGS-1 to 0.
    - ACK, then → WDATA for further bytes.
  - RDATA: shift reg[pointer] out MSB first, then release sda for bit 9 → RACK.
  - RACK: sample master ACK on the 9th rising edge.
    - ACK (0): pointer += 1 (wrapping), load next byte → RDATA.
    - NACK (1): → IGNORE. Pointer is still advanced.
- Simultaneous events:
  - START/STOP takes priority over bit processing in the same clk.
  - A write strobe and an external read of regs in the same clk: regs shows the old value that clk, the new value the next.
- A START that arrives with a partial byte discards that byte; no register changes.
- busy clears on STOP, START or IGNORE entry.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined:
  - A 3-tap majority filter follows each synchroniser on scl and sda. It suppresses pulses of 1 clk or less.
  - Edge-to-action latency becomes 5 clk.
- Undefined:
  - No filter; latency is 3 clk.
- Protocol behaviour is otherwise identical in both builds.

Test Plan:
- Reset low mid-read while sda is driven 0 → sda='z within 1 clk; regs=0; busy=0; ready=1.
- S, 0xA0, 0x01, 0x11, 0x22, 0x33, P (NUM_REGS=4) →
  - ACK on all bytes;
  - reg1=0x11, reg2=0x22, reg3=0x33;
  - 3 wr_stb pulses with wr_idx 1, 2, 3.
- S, 0xA0, 0x03, 0xAA, 0xBB, P → reg3=0xAA, then pointer wraps and reg0=0xBB.
- S, 0xA0, 0x02, Sr, 0xA1, read 3 bytes with ACK, ACK, NACK, P →
  - returns reg2, reg3, reg0;
  - sda released after the NACK.
- S, 0xA2 (wrong address), 0x00, 0x55, P → no ACK; no wr_stb; regs unchanged; busy stays 0.
- S, 0xA0, 0x07 (pointer ≥ NUM_REGS), 0x99, P → pointer byte NACKed; no register changes.
  - With I2C_GLITCH_FILTER_EN: a 1-clk scl glitch inserted mid-byte causes no extra bit shift.
